// File: rtl/run_length_monitor_pkg.sv
`default_nettype none
// ============================================================================
// run_monitor_pkg : shared record type, FSM encoding and counter width
// Revision: 1.0
// ============================================================================
package run_monitor_pkg;

  localparam int unsigned CNT_WIDTH     = 32;
  localparam int unsigned REC_LEN_WIDTH = 16;

  typedef struct packed {
    logic                     level;
    logic [REC_LEN_WIDTH-1:0] length;
    logic                     in_range;
  } run_record_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/run_length_monitor_fifo.sv
`default_nettype none
// ============================================================================
// run_record_fifo : first-word-fall-through record queue, registered head
// Revision: 1.0
// ============================================================================
module run_record_fifo
  import run_monitor_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = run_record_t
) (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_valid,
  output logic o_drop
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  T              r_mem     [DEPTH];
  T              w_mem_nxt [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_widx;
  logic          r_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;

  assign w_full      = (r_count == C_DEPTH);
  assign w_pop       = i_pop && r_valid;
  assign w_push_ok   = i_push && (!w_full || w_pop);
  assign o_drop      = i_push && w_full && !w_pop;
  assign w_widx      = r_count - CW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

  // Entries shift toward slot 0 on pop so the head is always a plain register.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_pop) begin
        w_mem_nxt[i] = r_mem[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push_ok && (w_widx == CW'(i))) begin
        w_mem_nxt[i] = i_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_data  = r_mem[0];
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/run_length_monitor.sv
`default_nettype none
// ============================================================================
// run_length_monitor : measures constant-level runs, range-checks and queues them
// Revision: 1.0
// ============================================================================
module run_length_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned STATE_0_MIN_VAL = 10,
  parameter int unsigned STATE_0_MAX_VAL = 20,
  parameter int unsigned STATE_1_MIN_VAL = 30,
  parameter int unsigned STATE_1_MAX_VAL = 40,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                 clk_i,
  input  logic                 a_rst_n_i,
  input  logic                 clear_i,
  input  logic                 state_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_level_o,
  output logic [LEN_WIDTH-1:0] m_length_o,
  output logic                 m_in_range_o,
  output logic [CNT_WIDTH-1:0] run_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 overflow_o
);

  typedef struct packed {
    logic                 level;
    logic [LEN_WIDTH-1:0] length;
    logic                 in_range;
  } rec_t;

  localparam longint unsigned      C_LEN_SAT_L = (64'd1 << LEN_WIDTH) - 64'd1;
  localparam logic [LEN_WIDTH-1:0] C_LEN_SAT   = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] C_S0_MIN    = LEN_WIDTH'(STATE_0_MIN_VAL);
  localparam logic [LEN_WIDTH-1:0] C_S0_MAX    = LEN_WIDTH'(STATE_0_MAX_VAL);
  localparam logic [LEN_WIDTH-1:0] C_S1_MIN    = LEN_WIDTH'(STATE_1_MIN_VAL);
  localparam logic [LEN_WIDTH-1:0] C_S1_MAX    = LEN_WIDTH'(STATE_1_MAX_VAL);
  localparam logic [CNT_WIDTH-1:0] C_CNT_SAT   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);

  if ((STATE_0_MIN_VAL > STATE_0_MAX_VAL) || (STATE_1_MIN_VAL > STATE_1_MAX_VAL)) begin : g_chk_order
    $error("run_length_monitor: a MIN limit exceeds its MAX limit");
  end
  if ((64'(STATE_0_MAX_VAL) >= C_LEN_SAT_L) || (64'(STATE_1_MAX_VAL) >= C_LEN_SAT_L)) begin : g_chk_width
    $error("run_length_monitor: a MAX limit does not fit below the LEN_WIDTH saturation value");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("run_length_monitor: FIFO_DEPTH must be a power of two and at least 2");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_level;
  logic                 w_level_nxt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] w_len_nxt;
  logic                 w_push;
  logic                 w_in_range;
  logic                 w_drop;
  rec_t                 w_rec;
  rec_t                 w_head;
  logic [CNT_WIDTH-1:0] r_run_cnt;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic                 r_overflow;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state <= IDLE;
      r_level <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_len_nxt   = r_len;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = RUN;
        w_level_nxt = state_i;
        w_len_nxt   = C_LEN_ONE;
      end
      RUN: begin
        if (state_i == r_level) begin
          if (r_len != C_LEN_SAT) begin
            w_len_nxt = r_len + C_LEN_ONE;
          end
        end else begin
          w_push      = 1'b1;
          w_level_nxt = state_i;
          w_len_nxt   = C_LEN_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A saturated length is out of range because every MAX sits below saturation.
  assign w_in_range = r_level ? ((r_len >= C_S1_MIN) && (r_len <= C_S1_MAX))
                              : ((r_len >= C_S0_MIN) && (r_len <= C_S0_MAX));
  assign w_rec      = {r_level, r_len, w_in_range};

  run_record_fifo #(
    .DEPTH (int'(FIFO_DEPTH)),
    .T     (rec_t)
  ) u_fifo (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .i_push    (w_push),
    .i_data    (w_rec),
    .i_pop     (m_ready_i),
    .o_data    (w_head),
    .o_valid   (m_valid_o),
    .o_drop    (w_drop)
  );

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_run_cnt  <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_run_cnt  <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && (r_run_cnt != C_CNT_SAT)) begin
        r_run_cnt <= r_run_cnt + C_CNT_ONE;
      end
      if (w_push && !w_in_range && (r_err_cnt != C_CNT_SAT)) begin
        r_err_cnt <= r_err_cnt + C_CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_level_o    = w_head.level;
  assign m_length_o   = w_head.length;
  assign m_in_range_o = w_head.in_range;
  assign run_cnt_o    = r_run_cnt;
  assign err_cnt_o    = r_err_cnt;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_run_length_monitor.sv
`default_nettype none
// ============================================================================
// tb_run_length_monitor : 16-bit and 6-bit length instances vs. a run model
// Revision: 1.0
// ============================================================================
module tb_run_length_monitor;

  localparam int W0 = 16;
  localparam int W1 = 6;
  localparam int DEPTH = 4;
  localparam int S0_MIN = 10, S0_MAX = 20, S1_MIN = 30, S1_MAX = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic st = 1'b0;
  logic ready = 1'b0;

  logic        v0, v1, lv0, lv1, ir0, ir1, ovf0, ovf1;
  logic [15:0] len0;
  logic [5:0]  len1;
  logic [31:0] rc0, rc1, ec0, ec1;

  always #5 clk = ~clk;

  run_length_monitor #(.LEN_WIDTH(W0)) u_dut16 (
    .clk_i(clk), .a_rst_n_i(rst_n), .clear_i(clear), .state_i(st),
    .m_valid_o(v0), .m_ready_i(ready), .m_level_o(lv0), .m_length_o(len0),
    .m_in_range_o(ir0), .run_cnt_o(rc0), .err_cnt_o(ec0), .overflow_o(ovf0)
  );

  run_length_monitor #(.LEN_WIDTH(W1)) u_dut6 (
    .clk_i(clk), .a_rst_n_i(rst_n), .clear_i(clear), .state_i(st),
    .m_valid_o(v1), .m_ready_i(ready), .m_level_o(lv1), .m_length_o(len1),
    .m_in_range_o(ir1), .run_cnt_o(rc1), .err_cnt_o(ec1), .overflow_o(ovf1)
  );

  // Reference: a run is a maximal stretch of equal samples; its reported
  // length is the sample count clipped to the width's all-ones value.
  typedef struct {
    bit          level;
    int unsigned length;
    bit          in_range;
  } exp_rec_t;

  exp_rec_t    q0[$];
  exp_rec_t    q1[$];
  bit          m_idle [2];
  bit          m_cur  [2];
  int unsigned m_cnt  [2];
  int unsigned m_run  [2];
  int unsigned m_err  [2];
  bit          m_ovf  [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(int k);
    if (k == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_rec_t qfront(int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpush(int k, exp_rec_t r);
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1; m_cur[k] = 1'b0; m_cnt[k] = 0;
      m_run[k] = 0; m_err[k] = 0; m_ovf[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      int unsigned sat;
      bit          done;
      bit          pop;
      exp_rec_t    rec;
      sat  = (k == 0) ? ((1 << W0) - 1) : ((1 << W1) - 1);
      done = 1'b0;
      pop  = (qsize(k) > 0) && ready;
      if (m_idle[k]) begin
        m_idle[k] = 1'b0; m_cur[k] = st; m_cnt[k] = 1;
      end else if (st == m_cur[k]) begin
        if (m_cnt[k] < 32'h0010_0000) m_cnt[k]++;
      end else begin
        done = 1'b1;
        rec.level  = m_cur[k];
        rec.length = (m_cnt[k] > sat) ? sat : m_cnt[k];
        rec.in_range = m_cur[k] ? (rec.length >= S1_MIN && rec.length <= S1_MAX)
                                : (rec.length >= S0_MIN && rec.length <= S0_MAX);
        m_cur[k] = st; m_cnt[k] = 1;
      end
      if (pop) qpop(k);
      if (done) begin
        if (qsize(k) < DEPTH) qpush(k, rec);
        else                  m_ovf[k] = 1'b1;
      end
      if (clear) begin
        m_run[k] = 0; m_err[k] = 0; m_ovf[k] = 1'b0;
      end else if (done) begin
        if (m_run[k] != 32'hFFFF_FFFF) m_run[k]++;
        if (!rec.in_range && m_err[k] != 32'hFFFF_FFFF) m_err[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic        dv, dl, dir, dovf;
      logic [63:0] dlen;
      logic [31:0] drc, dec;
      string       w;
      exp_rec_t    e;
      if (k == 0) begin
        dv = v0; dl = lv0; dir = ir0; dovf = ovf0; dlen = 64'(len0); drc = rc0; dec = ec0; w = "w16";
      end else begin
        dv = v1; dl = lv1; dir = ir1; dovf = ovf1; dlen = 64'(len1); drc = rc1; dec = ec1; w = "w6";
      end
      check_eq({w, " valid"}, dv, qsize(k) > 0);
      if (qsize(k) > 0) begin
        e = qfront(k);
        check_eq({w, " level"}, dl, e.level);
        check_eq({w, " length"}, dlen, e.length);
        check_eq({w, " in_range"}, dir, e.in_range);
      end
      check_eq({w, " run_cnt"}, drc, m_run[k]);
      check_eq({w, " err_cnt"}, dec, m_err[k]);
      check_eq({w, " overflow"}, dovf, m_ovf[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic lvl, input int n);
    st = lvl;
    repeat (n) step();
  endtask

  initial begin
    logic lv;
    model_reset();
    #1 rst_n = 1'b0;
    st = 1'b0; ready = 1'b1; clear = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst valid", v0, 1'b0);
    check_eq("rst level", lv0, 1'b0);
    check_eq("rst length", 64'(len0), 0);
    check_eq("rst in_range", ir0, 1'b0);
    check_eq("rst run_cnt", rc0, 0);
    check_eq("rst err_cnt", ec0, 0);
    check_eq("rst overflow", ovf1, 1'b0);
    check_all();
    rst_n = 1'b1;

    // In-range and out-of-range runs with the consumer always ready
    hold(0, 15); hold(1, 35); hold(0, 12); hold(1, 35);
    hold(0, 9);  hold(1, 41); hold(0, 5);
    check_eq("dir run_cnt", rc0, 6);
    check_eq("dir err_cnt", ec0, 2);

    // Stalled consumer with length-1 runs: overflow, then ordered drain
    clear = 1'b1; step(); clear = 1'b0;
    ready = 1'b0;
    repeat (7) begin st = ~st; step(); end
    check_eq("stall overflow", ovf0, 1'b1);
    repeat (4) step();
    ready = 1'b1;
    repeat (6) step();

    // Full FIFO with a pop and a completion in the same cycle
    clear = 1'b1; step(); clear = 1'b0;
    ready = 1'b0;
    repeat (4) begin st = ~st; step(); end
    ready = 1'b1; st = ~st; step();
    check_eq("full push+pop overflow", ovf0, 1'b0);
    repeat (6) step();

    // Long low run saturates the 6-bit length
    hold(1, 2); hold(0, 100); hold(1, 1);
    check_eq("sat len6", 64'(len1), 63);
    check_eq("sat len16", 64'(len0), 100);
    check_eq("sat in_range6", ir1, 1'b0);
    hold(1, 3);

    // Random runs, random back-pressure, occasional clear
    for (int r = 0; r < 60; r++) begin
      int n;
      n = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
      st = ~st;
      for (int c = 0; c < n; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 40) == 0);
        step();
      end
    end
    clear = 1'b0;

    // Reset mid-run with two records queued
    ready = 1'b1;
    repeat (8) step();
    ready = 1'b0;
    st = ~st; step();
    st = ~st; step();
    repeat (3) step();
    check_eq("pre-rst valid", v0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async rst valid16", v0, 1'b0);
    check_eq("async rst valid6", v1, 1'b0);
    check_eq("async rst run_cnt", rc0, 0);
    check_eq("async rst err_cnt", ec0, 0);
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    ready = 1'b1;
    lv = st;
    hold(lv, 7);
    hold(~lv, 1);
    check_eq("post-rst valid", v0, 1'b1);
    check_eq("post-rst length", 64'(len0), 7);
    check_eq("post-rst run_cnt", rc0, 1);
    hold(~lv, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
